// File: rtl/data_memory_bist.sv
// ---------------------------------------------------------------------------
// data_memory_bist
//
// Built-in self-test initiator for the word-addressed data memory of the
// multi-cycle datapath. A run writes E0(a) = PATTERN ^ a to every address,
// reads it back, then writes E1(a) = ~(PATTERN ^ a), and reads that back.
// The block reports pass/fail and the first failing address. While busy it
// owns the memory ports. The port mux to the datapath lives outside.
//
// Parameters:
//   DEPTH        - number of words tested, addresses 0..DEPTH-1 (1..65536)
//   PATTERN      - base data word
//   READ_LATENCY - 0: RD is combinational from A, 1: RD is registered
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   start     in   begin a run (sampled only in IDLE)
//   busy      out  run in progress
//   done      out  one-cycle pulse at the end of a run
//   pass      out  result of the last run
//   fail_addr out  first failing address of the last run
//   WE        out  memory write enable (registered)
//   A         out  memory word address (registered)
//   WD        out  memory write data (registered)
//   RD        in   memory read data
//
// Optional feature macro:
//   DMBIST_STOP_ON_FAIL_EN - when defined, the first mismatch aborts the run
//                            and jumps straight to DONE.
// ---------------------------------------------------------------------------
module data_memory_bist #(
  parameter int          DEPTH        = 64,
  parameter logic [31:0] PATTERN      = 32'hA5A5_5A5A,
  parameter int          READ_LATENCY = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_addr,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

`ifdef DMBIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [15:0] LAST = 16'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE} state_t;

  state_t      state, next_state;
  logic [15:0] addr, next_addr;
  logic        next_we;
  logic [31:0] next_wd;
  logic        accept;

  logic        rd_phase;
  logic [31:0] exp_now;
  logic        cmp_valid;
  logic [31:0] cmp_exp;
  logic [15:0] cmp_addr;
  logic        mismatch;

  function automatic logic [31:0] pat0(input logic [15:0] a);
    return PATTERN ^ {16'h0000, a};
  endfunction

  assign busy     = (state == WR0) || (state == RD0) || (state == WR1) ||
                    (state == RD1) || (state == DRAIN);
  assign done     = (state == DONE);
  assign rd_phase = (state == RD0) || (state == RD1);
  assign exp_now  = (state == RD1) ? ~pat0(addr) : pat0(addr);

  // The compare stage trails the issued read by READ_LATENCY cycles. With a
  // registered memory the data for the last RD0 address arrives during the
  // first WR1 cycle; it was captured before that write, so it stays valid.
  generate
    if (READ_LATENCY == 0) begin : g_cmp_comb
      assign cmp_valid = rd_phase;
      assign cmp_exp   = exp_now;
      assign cmp_addr  = addr;
    end else begin : g_cmp_reg
      logic        valid_q;
      logic [31:0] exp_q;
      logic [15:0] addr_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          valid_q <= 1'b0;
          exp_q   <= 32'h0;
          addr_q  <= 16'h0;
        end else begin
          valid_q <= rd_phase;
          exp_q   <= exp_now;
          addr_q  <= addr;
        end
      end

      assign cmp_valid = valid_q;
      assign cmp_exp   = exp_q;
      assign cmp_addr  = addr_q;
    end
  endgenerate

  // Only compares that land while the run is live count; a compare left in
  // flight by an early abort falls into DONE where busy is low.
  assign mismatch = cmp_valid && busy && (RD != cmp_exp);

  // Next-state, next-address and the values the registered memory outputs
  // take on the coming edge.
  always_comb begin
    next_state = state;
    next_addr  = addr;
    accept     = 1'b0;
    next_we    = 1'b0;
    next_wd    = 32'h0;

    case (state)
      IDLE: begin
        next_addr = 16'h0;
        if (start) begin
          accept     = 1'b1;
          next_state = WR0;
        end
      end
      WR0: begin
        if (addr == LAST) begin
          next_state = RD0;
          next_addr  = 16'h0;
        end else begin
          next_addr = addr + 16'd1;
        end
      end
      RD0: begin
        if (addr == LAST) begin
          next_state = WR1;
          next_addr  = 16'h0;
        end else begin
          next_addr = addr + 16'd1;
        end
      end
      WR1: begin
        if (addr == LAST) begin
          next_state = RD1;
          next_addr  = 16'h0;
        end else begin
          next_addr = addr + 16'd1;
        end
      end
      RD1: begin
        if (addr == LAST) begin
          next_state = (READ_LATENCY == 1) ? DRAIN : DONE;
          next_addr  = 16'h0;
        end else begin
          next_addr = addr + 16'd1;
        end
      end
      DRAIN: begin
        next_state = DONE;
        next_addr  = 16'h0;
      end
      DONE: begin
        next_state = IDLE;
        next_addr  = 16'h0;
      end
      default: begin
        next_state = IDLE;
        next_addr  = 16'h0;
      end
    endcase

    if (STOP_ON_FAIL && mismatch) begin
      next_state = DONE;
      next_addr  = 16'h0;
    end

    if (next_state == WR0) begin
      next_we = 1'b1;
      next_wd = pat0(next_addr);
    end else if (next_state == WR1) begin
      next_we = 1'b1;
      next_wd = ~pat0(next_addr);
    end
  end

  // State, address counter, registered memory outputs and the result flags.
  // A start clears the result; afterwards only the first mismatch lands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      addr      <= 16'h0;
      WE        <= 1'b0;
      A         <= 32'h0;
      WD        <= 32'h0;
      pass      <= 1'b0;
      fail_addr <= 32'h0;
    end else begin
      state <= next_state;
      addr  <= next_addr;
      WE    <= next_we;
      A     <= {16'h0000, next_addr};
      WD    <= next_wd;
      if (accept) begin
        pass      <= 1'b1;
        fail_addr <= 32'h0;
      end else if (mismatch && pass) begin
        pass      <= 1'b0;
        fail_addr <= {16'h0000, cmp_addr};
      end
    end
  end

endmodule

// File: doc/data_memory_bist.md
# data_memory_bist

- Built-in self-test initiator for the multi-cycle datapath's word-addressed data memory; the bench-side writer/reader becomes synthesizable.
- Drives the memory's write-enable, address and write-data ports, reads back through its read-data port, and reports pass/fail plus the first failing address.
- Sits beside the datapath and owns the memory ports while busy; the memory port mux is outside this block.

## Interface

Parameters:
- DEPTH, 64: number of words tested, addresses 0..DEPTH-1; legal range 1..2^16.
- PATTERN, 32'hA5A5_5A5A: base data word.
- READ_LATENCY, 0: memory read latency in cycles. 0 means RD is combinational from A; 1 means RD is registered. No other values are legal.

Ports:
- CLK, input, 1: single clock; all logic is on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- start, input, 1: begin a test run; sampled only in IDLE.
- busy, output, 1: high while a run is in progress.
- done, output, 1: one-cycle pulse at the end of a run.
- pass, output, 1: result of the last run; valid from done until the next start.
- fail_addr, output, 32: first failing address of the last run.
- WE, output, 1: memory write enable.
- A, output, 32: memory word address.
- WD, output, 32: memory write data.
- RD, input, 32: memory read data.

## Operation

- States: IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE.
- Expected data: E0(a) = PATTERN ^ a. E1(a) = ~(PATTERN ^ a).
- IDLE:
  - WE = 0.
  - On start: go to WR0, address counter = 0, pass = 1, fail_addr = 0.
- WR0:
  - WE = 1, A = a, WD = E0(a); one word per cycle.
  - After a = DEPTH-1, go to RD0 with a = 0.
- RD0:
  - WE = 0, A = a; RD is compared against E0(a).
  - The compare uses an expected/address pipeline delayed by READ_LATENCY.
  - After issuing a = DEPTH-1, go to WR1.
- WR1: same as WR0 but writes E1(a).
- RD1: same as RD0 but compares against E1(a).
- DRAIN:
  - Entered after RD1 only when READ_LATENCY = 1.
  - Lasts READ_LATENCY cycles, then goes to DONE.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - busy falls in the same cycle.
- On a mismatch with pass still 1:
  - pass goes to 0 and fail_addr latches the compared address.
  - Later mismatches do not update fail_addr.
- Phase boundary with READ_LATENCY = 1:
  - The last RD0 compare lands in the first WR1 cycle. The pipeline still completes it.
  - A write in that same cycle does not corrupt the compare, because the data was already registered.
- Address counter: 16 bits, zero-extended onto A; it never wraps past DEPTH-1.
- start while busy is ignored.
- start asserted in the same cycle as done is ignored; it must be re-asserted in IDLE.

## Timing

- Reset values: WE = 0, A = 0, WD = 0, busy = 0, done = 0, pass = 0, fail_addr = 0, state = IDLE.
- RST mid-run: the next edge gives IDLE and all outputs return to reset values. No further writes occur.
- busy rises on the edge after start is sampled. The first WE = 1 cycle is the same cycle.
- Run length from busy rising to done pulse: 4*DEPTH + READ_LATENCY cycles of busy, then the done cycle.
- WE, A and WD are registered outputs. Each write occupies exactly one cycle.
- DEPTH = 1: each phase lasts one cycle and the run still performs four accesses.
- pass and fail_addr are stable from the done cycle until the next accepted start.

## Configuration

- DMBIST_STOP_ON_FAIL_EN
  - Defined: on the first mismatch the FSM goes straight to DONE on the next edge. WE is forced to 0, and remaining accesses and compares are abandoned. The done pulse follows at once.
  - Undefined: the run always completes all four phases regardless of mismatches. Only the first failure is recorded.

## Test plan

- Clean memory, DEPTH = 4, READ_LATENCY = 0, start pulse:
  - Writes 0xA5A55A5A, 0xA5A55A5B, 0xA5A55A58, 0xA5A55A59 to A = 0..3.
  - Then 16 busy cycles in total, done pulse, pass = 1, fail_addr = 0.
- Memory model with bit 0 stuck at 1 at address 2, DEPTH = 4:
  - The RD0 compare at A = 2 fails (expected 0xA5A55A58).
  - Result: pass = 0, fail_addr = 2.
  - Without the macro: 16 busy cycles. With the macro: done is seen in the cycle after the failing compare.
- Registered-read memory, READ_LATENCY = 1, clean, DEPTH = 4:
  - 17 busy cycles, pass = 1.
  - The compare at the RD0-to-WR1 boundary is checked.
- RST asserted on the 6th busy cycle:
  - Next edge: WE = 0, busy = 0, pass = 0, and no done pulse.
  - A new start then runs normally to pass = 1.
- start held high for the entire run:
  - Exactly one run is performed; start is ignored in the done cycle.
  - Deasserting start and asserting it again starts a second run.
- DEPTH = 1: A stays 0 for all four accesses, with WD of 0xA5A55A5A then 0x5A5AA5A5. Result: 4 busy cycles, pass = 1.
